// File: rtl/mux_pkg.sv
// Shared types and defaults for the N-channel registered mux.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 4;

endpackage

// File: rtl/mux_n_rr_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at N-1 -> 0.
// Purely combinational; ptr is assumed to be < N.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [SELW:0] c;

  // Scan N positions starting at ptr; the first requesting channel wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = '0;
    for (int k = 0; k < N; k++) begin
      c = {1'b0, ptr} + (SELW+1)'(k);
      if (c >= N_W) c = c - N_W;
      if (!any && req[c[SELW-1:0]]) begin
        any                = 1'b1;
        grant[c[SELW-1:0]] = 1'b1;
        idx                = c[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with explicit-select and round-robin modes.
//
// Handshake: a word moves on channel i at a rising clk edge exactly when
// in_valid[i] && in_ready[i]; a word leaves the output register when
// out_valid && out_ready. in_ready depends on out_ready combinationally
// (load_en = !out_valid || out_ready), so there is no skid buffer; producers
// hold in_valid/in_data stable until accepted.
module mux_n_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  localparam logic [SELW:0]   N_W  = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N-1);

  mux_mode_e        cur_mode;
  logic             load_en;
  logic             sel_ok;
  logic [N-1:0]     sel_gnt;
  logic [N-1:0]     rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_ptr_nxt;

  assign cur_mode = mux_mode_e'(mode);
  assign load_en  = !out_valid || out_ready;
  assign sel_ok   = ({1'b0, sel} < N_W);

  // Explicit-select grant: only an in-range sel on a valid channel is granted.
  always_comb begin
    sel_gnt = '0;
    if (sel_ok) begin
      if (in_valid[sel]) sel_gnt[sel] = 1'b1;
    end
  end

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Choose the active grant source and pick the granted channel's data.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    gnt_data = '0;
    if (cur_mode == MODE_RR) begin
      grant   = rr_gnt;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      grant   = sel_gnt;
      gnt_idx = sel;
      gnt_any = |sel_gnt;
    end
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready   = load_en ? grant : '0;
  assign xfer       = load_en && gnt_any;
  assign rr_ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  // Output register and round-robin pointer; the pointer moves only on RR transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
      if (cur_mode == MODE_RR) rr_ptr <= rr_ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed bench for mux_n_rr: a 4-channel instance for the main paths and a
// 3-channel instance for out-of-range select and non-power-of-2 wrap.
module tb_mux_n_rr;

  logic        clk;
  logic        rst_n;

  // N=4 instance
  logic        mode4;
  logic [1:0]  sel4;
  logic [3:0]  in_valid4;
  logic [31:0] in_data4;
  logic [3:0]  in_ready4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_chan4;
  logic        out_ready4;

  // N=3 instance
  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_ready3;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  mux_n_rr #(.WIDTH(8), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
    .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_chan(out_chan4),
    .out_ready(out_ready4)
  );

  mux_n_rr #(.WIDTH(8), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3),
    .out_ready(out_ready3)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    mode4      = 1'b0;
    sel4       = 2'd0;
    in_valid4  = 4'b0000;
    in_data4   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready4 = 1'b0;
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_valid3  = 3'b000;
    in_data3   = {8'hc3, 8'hb2, 8'ha1};
    out_ready3 = 1'b0;

    // Reset state
    tick();
    chk("rst_valid", {31'd0, out_valid4}, 32'd0);
    chk("rst_data",  {24'd0, out_data4}, 32'd0);
    chk("rst_chan",  {30'd0, out_chan4}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // SEL mode, sel=2 then sel=3
    mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    settle();
    chk("sel2_ready", {28'd0, in_ready4}, 32'h4);
    tick();
    chk("sel2_valid", {31'd0, out_valid4}, 32'd1);
    chk("sel2_data",  {24'd0, out_data4}, 32'h33);
    chk("sel2_chan",  {30'd0, out_chan4}, 32'd2);
    sel4 = 2'd3;
    settle();
    chk("sel3_ready", {28'd0, in_ready4}, 32'h8);
    tick();
    chk("sel3_data", {24'd0, out_data4}, 32'h44);
    chk("sel3_chan", {30'd0, out_chan4}, 32'd3);

    // RR mode, all valid: pointer still 0 after SEL transfers -> 0,1,2,3,0,1
    mode4 = 1'b1;
    exp_q = {8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tick();
      chk("rr_all_chan", {30'd0, out_chan4}, {24'd0, e});
      chk("rr_all_data", {24'd0, out_data4}, 32'h11 * (32'(e) + 1));
    end

    // RR with 1001, pointer at 2 -> 3,0,3
    in_valid4 = 4'b1001;
    exp_q = {8'd3, 8'd0, 8'd3};
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tick();
      chk("rr_1001_chan", {30'd0, out_chan4}, {24'd0, e});
    end

    // Backpressure: holding ch3 word, only ch1 requesting, pointer at 0
    out_ready4 = 1'b0; in_valid4 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", {28'd0, in_ready4}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, out_valid4}, 32'd1);
      chk("bp_data",  {24'd0, out_data4}, 32'h44);
      chk("bp_chan",  {30'd0, out_chan4}, 32'd3);
    end
    out_ready4 = 1'b1;
    settle();
    chk("bp_release_ready", {28'd0, in_ready4}, 32'h2);
    tick();
    chk("b2b_data0", {24'd0, out_data4}, 32'h22);
    chk("b2b_chan0", {30'd0, out_chan4}, 32'd1);
    in_data4[15:8] = 8'h55;
    tick();
    chk("b2b_valid1", {31'd0, out_valid4}, 32'd1);
    chk("b2b_data1",  {24'd0, out_data4}, 32'h55);
    chk("b2b_chan1",  {30'd0, out_chan4}, 32'd1);

    // Mode switch: last RR grant was ch1 so pointer is 2; two SEL ch0 transfers
    in_data4 = {8'h84, 8'h83, 8'h82, 8'h81};
    mode4 = 1'b0; sel4 = 2'd0; in_valid4 = 4'b1111;
    tick();
    chk("ms_sel0_chan_a", {30'd0, out_chan4}, 32'd0);
    tick();
    chk("ms_sel0_data_b", {24'd0, out_data4}, 32'h81);
    mode4 = 1'b1;
    tick();
    chk("ms_rr_chan", {30'd0, out_chan4}, 32'd2);
    chk("ms_rr_data", {24'd0, out_data4}, 32'h83);

    // SEL on an idle channel: no grant, output drains, data/chan hold
    mode4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b1101;
    settle();
    chk("idle_ready", {28'd0, in_ready4}, 32'd0);
    tick();
    chk("idle_valid", {31'd0, out_valid4}, 32'd0);
    chk("idle_data",  {24'd0, out_data4}, 32'h83);
    chk("idle_chan",  {30'd0, out_chan4}, 32'd2);

    // N=3: sel=3 is out of range, never granted
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("n3_sel3_ready", {29'd0, in_ready3}, 32'd0);
      tick();
      chk("n3_sel3_valid", {31'd0, out_valid3}, 32'd0);
    end

    // N=3 RR wrap: 0,1,2,0
    mode3 = 1'b1;
    exp_q = {8'd0, 8'd1, 8'd2, 8'd0};
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tick();
      chk("n3_rr_chan", {30'd0, out_chan3}, {24'd0, e});
      chk("n3_rr_data", {24'd0, out_data3}, 32'ha1 + 32'h11 * 32'(e));
    end
    in_valid3 = 3'b000;

    // Asynchronous reset mid-cycle while holding data; u4 pointer is 3 here
    mode4 = 1'b0; sel4 = 2'd0; in_valid4 = 4'b0001; out_ready4 = 1'b1;
    tick();
    chk("pre_rst_valid", {31'd0, out_valid4}, 32'd1);
    out_ready4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid4}, 32'd0);
    chk("async_rst_data",  {24'd0, out_data4}, 32'd0);
    chk("async_rst_chan",  {30'd0, out_chan4}, 32'd0);
    #1 rst_n = 1'b1;

    // Pointer returned to 0: RR with all valid grants ch0 first
    mode4 = 1'b1; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    tick();
    chk("post_rst_rr_chan", {30'd0, out_chan4}, 32'd0);
    chk("post_rst_rr_data", {24'd0, out_data4}, 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
